// File: rtl/pport_pkg.sv
// Shared encodings for the parallel-port transmit arbiter.
package pport_pkg;

  typedef enum logic {
    PPA_IDLE   = 1'b0,
    PPA_LOCKED = 1'b1
  } ppa_state_t;

  localparam logic PPA_REQ_A = 1'b0;
  localparam logic PPA_REQ_B = 1'b1;

endpackage

// File: rtl/pport_arbiter.sv
// Packet-locked two-way round-robin onto the parallel-port byte stream; one registered stage, byte visible the cycle after acceptance.
// Requester busy follows the output register's room; a stalled owner is released by the idle watchdog.
module pport_arbiter
  import pport_pkg::*;
#(
  parameter int unsigned LGTIMEOUT = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_a_stb,
  input  logic [6:0] i_a_data,
  input  logic       i_a_last,
  output logic       o_a_busy,
  input  logic       i_b_stb,
  input  logic [6:0] i_b_data,
  input  logic       i_b_last,
  output logic       o_b_busy,
  output logic       o_pp_stb,
  output logic [6:0] o_pp_data,
  input  logic       i_pp_busy,
  output logic       o_grant,
  output logic       o_locked,
  output logic       o_timeout
);

  // Release happens on the idle cycle that would take the count to all ones.
  localparam logic [LGTIMEOUT-1:0] WD_PRE = LGTIMEOUT'((1 << LGTIMEOUT) - 2);

  ppa_state_t           r_state, w_state_nxt;
  logic                 r_ptr, w_ptr_nxt;
  logic                 r_grant, w_grant_nxt;
  logic [LGTIMEOUT-1:0] r_wdog, w_wdog_nxt;
  logic                 r_timeout, w_timeout_nxt;
  logic                 r_pp_stb;
  logic [6:0]           r_pp_data;

  logic                 w_load_ok;
  logic                 w_sel;
  logic                 w_accept;
  logic                 w_acc_last;
  logic [6:0]           w_acc_data;
  logic                 w_a_busy, w_b_busy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= PPA_IDLE;
      r_ptr     <= PPA_REQ_A;
      r_grant   <= PPA_REQ_A;
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_grant   <= w_grant_nxt;
      r_wdog    <= w_wdog_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_load_ok     = !r_pp_stb || !i_pp_busy;
    w_sel         = r_grant;
    w_accept      = 1'b0;
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_grant_nxt   = r_grant;
    w_wdog_nxt    = r_wdog;
    w_timeout_nxt = 1'b0;

    if (r_state == PPA_IDLE) begin
      if (i_a_stb && i_b_stb) w_sel = r_ptr;
      else if (i_b_stb)       w_sel = PPA_REQ_B;
      else                    w_sel = PPA_REQ_A;
      w_accept = w_load_ok && (i_a_stb || i_b_stb);
    end else begin
      w_accept = w_load_ok && ((w_sel == PPA_REQ_B) ? i_b_stb : i_a_stb);
    end

    w_acc_last = (w_sel == PPA_REQ_B) ? i_b_last : i_a_last;
    w_acc_data = (w_sel == PPA_REQ_B) ? i_b_data : i_a_data;
    w_a_busy   = !(w_load_ok && (w_sel == PPA_REQ_A));
    w_b_busy   = !(w_load_ok && (w_sel == PPA_REQ_B));

    // An acceptance always beats a watchdog expiry in the same cycle.
    if (w_accept) begin
      w_grant_nxt = w_sel;
      w_wdog_nxt  = '0;
      if (w_acc_last) begin
        w_state_nxt = PPA_IDLE;
        w_ptr_nxt   = !w_sel;
      end else begin
        w_state_nxt = PPA_LOCKED;
      end
    end else if (r_state == PPA_LOCKED) begin
      if (r_wdog == WD_PRE) begin
        w_state_nxt   = PPA_IDLE;
        w_ptr_nxt     = !r_grant;
        w_wdog_nxt    = '0;
        w_timeout_nxt = 1'b1;
      end else begin
        w_wdog_nxt = r_wdog + LGTIMEOUT'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pp_stb  <= 1'b0;
      r_pp_data <= '0;
    end else if (w_accept) begin
      r_pp_stb  <= 1'b1;
      r_pp_data <= w_acc_data;
    end else if (!i_pp_busy) begin
      r_pp_stb  <= 1'b0;
    end
  end

  assign o_a_busy  = i_rst || w_a_busy;
  assign o_b_busy  = i_rst || w_b_busy;
  assign o_pp_stb  = r_pp_stb;
  assign o_pp_data = r_pp_data;
  assign o_grant   = r_grant;
  assign o_locked  = (r_state == PPA_LOCKED);
  assign o_timeout = r_timeout;

endmodule
